bcd_timekeeper: RTL and testbench

Parametrised time-of-day core for the wall-clock designs, and the successor to the fixed 24-hour counter.
- Prescaler with a configurable tick rate drives a 0..59 seconds counter, BCD minutes and a 0..23 binary hour.
- Hours are presented as 24-hour or 12-hour BCD with a PM flag.
- Adds a minute-resolution alarm.
- Sits between the debounced button pulses and the seven-segment driver.

---
 rtl/bcd_timekeeper_pkg.sv | 14 +
 rtl/hour_display_fmt.sv | 34 +++
 rtl/bcd_timekeeper.sv | 125 ++++++++++++
 tb/tb_bcd_timekeeper.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timekeeper_pkg.sv
// Shared limits and BCD helper for the time-of-day core and its display formatter.
package bcd_timekeeper_pkg;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;
    localparam int HR_NOON = 12;

    // Returns {tens, units}; only meaningful for inputs 0..99.
    function automatic logic [7:0] bin2bcd_0to99(input logic [6:0] bin);
        return {4'(bin / 7'd10), 4'(bin % 7'd10)};
    endfunction

endpackage

// File: rtl/hour_display_fmt.sv
// Maps the binary 0..23 hour to BCD display digits in 24h or 12h form with a PM flag.
// Latency: combinational. Backpressure: none.
// 12h mode shows midnight and noon as 12; pm is forced low in 24h mode.
module hour_display_fmt
    import bcd_timekeeper_pkg::*;
(
    input  logic [4:0] hour,
    input  logic       mode12,
    output logic [3:0] hours2,
    output logic [3:0] hours1,
    output logic       pm
);

    logic [6:0] disp;
    logic [7:0] bcd;

    always_comb begin
        disp = {2'b00, hour};
        pm   = 1'b0;
        if (mode12) begin
            pm = (hour >= 5'(HR_NOON));
            if (hour == 5'd0) begin
                disp = 7'(HR_NOON);
            end else if (hour > 5'(HR_NOON)) begin
                disp = {2'b00, hour - 5'(HR_NOON)};
            end
        end
        bcd = bin2bcd_0to99(disp);
    end

    assign hours2 = bcd[7:4];
    assign hours1 = bcd[3:0];

endmodule

// File: rtl/bcd_timekeeper.sv
// Time-of-day core: prescaler, seconds, BCD minutes, binary hour, display formatting and alarm.
// Latency: state updates on the clock edge; display digits are combinational from state.
// Backpressure: none; button pulses are accepted every cycle and merged with carries.
module bcd_timekeeper
    import bcd_timekeeper_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000
)(
    input  logic       CLK100MHZ,
    input  logic       nReset,
    input  logic       clear,
    input  logic       mode12,
    input  logic       inc_min,
    input  logic       inc_hr,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    input  logic       alarm_ack,
    output logic       sec_tick,
    output logic [5:0] seconds,
    output logic [3:0] hours2,
    output logic [3:0] hours1,
    output logic [3:0] minutes2,
    output logic [3:0] minutes1,
    output logic       pm,
    output logic       alarm
);

    localparam int CNT_W = $clog2(TICKS_PER_SEC);

    logic [CNT_W-1:0] presc;
    logic [4:0]       hour;

    logic       tick_now;
    logic       auto_carry;
    logic       min_req;
    logic       min_wrap;
    logic       hr_carry;
    logic       hr_req;
    logic [3:0] min_tens_nxt;
    logic [3:0] min_units_nxt;
    logic [4:0] hour_nxt;
    logic       alarm_in_range;
    logic       alarm_set;

    assign tick_now   = (presc == CNT_W'(TICKS_PER_SEC - 1));
    assign auto_carry = tick_now && (seconds == 6'(SEC_MAX));
    assign min_req    = auto_carry || inc_min;
    assign min_wrap   = (minutes2 == 4'(MIN_MAX / 10)) && (minutes1 == 4'(MIN_MAX % 10));
    // Only a rollover driven by the seconds counter carries into the hour.
    assign hr_carry   = auto_carry && min_wrap;
    assign hr_req     = hr_carry || inc_hr;

    always_comb begin
        min_tens_nxt  = minutes2;
        min_units_nxt = minutes1;
        if (min_req) begin
            if (min_wrap) begin
                min_tens_nxt  = 4'd0;
                min_units_nxt = 4'd0;
            end else if (minutes1 == 4'd9) begin
                min_tens_nxt  = minutes2 + 4'd1;
                min_units_nxt = 4'd0;
            end else begin
                min_units_nxt = minutes1 + 4'd1;
            end
        end
    end

    always_comb begin
        hour_nxt = hour;
        if (hr_req) begin
            hour_nxt = (hour == 5'(HR_MAX)) ? 5'd0 : hour + 5'd1;
        end
    end

    // Compare against the post-edge time so the flag rises together with the displayed match.
    assign alarm_in_range = (alarm_hr <= 5'(HR_MAX)) && (alarm_min <= 6'(MIN_MAX));
    assign alarm_set      = auto_carry && alarm_en && alarm_in_range
                            && (hour_nxt == alarm_hr)
                            && ({min_tens_nxt, min_units_nxt} == bin2bcd_0to99({1'b0, alarm_min}));

    always_ff @(posedge CLK100MHZ or negedge nReset) begin
        if (!nReset) begin
            presc    <= '0;
            sec_tick <= 1'b0;
            seconds  <= 6'd0;
            minutes2 <= 4'd0;
            minutes1 <= 4'd0;
            hour     <= 5'd0;
            alarm    <= 1'b0;
        end else if (clear) begin
            presc    <= '0;
            sec_tick <= 1'b0;
            seconds  <= 6'd0;
            minutes2 <= 4'd0;
            minutes1 <= 4'd0;
            hour     <= 5'd0;
            alarm    <= 1'b0;
        end else begin
            presc    <= tick_now ? '0 : presc + 1'b1;
            sec_tick <= tick_now;
            if (tick_now) begin
                seconds <= (seconds == 6'(SEC_MAX)) ? 6'd0 : seconds + 6'd1;
            end
            minutes2 <= min_tens_nxt;
            minutes1 <= min_units_nxt;
            hour     <= hour_nxt;
            if (alarm_set) begin
                alarm <= 1'b1;
            end else if (alarm_ack || !alarm_en) begin
                alarm <= 1'b0;
            end
        end
    end

    hour_display_fmt u_hour_fmt (
        .hour   (hour),
        .mode12 (mode12),
        .hours2 (hours2),
        .hours1 (hours1),
        .pm     (pm)
    );

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Bench for bcd_timekeeper with a 4-tick second: reference model feeds a scoreboard queue.
module tb_bcd_timekeeper;

    localparam int TPS = 4;

    logic       CLK100MHZ = 1'b0;
    logic       nReset    = 1'b0;
    logic       clear     = 1'b0;
    logic       mode12    = 1'b0;
    logic       inc_min   = 1'b0;
    logic       inc_hr    = 1'b0;
    logic       alarm_en  = 1'b0;
    logic [4:0] alarm_hr  = 5'd0;
    logic [5:0] alarm_min = 6'd0;
    logic       alarm_ack = 1'b0;
    logic       sec_tick;
    logic [5:0] seconds;
    logic [3:0] hours2, hours1, minutes2, minutes1;
    logic       pm;
    logic       alarm;

    bcd_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
        .CLK100MHZ (CLK100MHZ),
        .nReset    (nReset),
        .clear     (clear),
        .mode12    (mode12),
        .inc_min   (inc_min),
        .inc_hr    (inc_hr),
        .alarm_en  (alarm_en),
        .alarm_hr  (alarm_hr),
        .alarm_min (alarm_min),
        .alarm_ack (alarm_ack),
        .sec_tick  (sec_tick),
        .seconds   (seconds),
        .hours2    (hours2),
        .hours1    (hours1),
        .minutes2  (minutes2),
        .minutes1  (minutes1),
        .pm        (pm),
        .alarm     (alarm)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    // Reference model state, all binary.
    int m_cnt = 0, m_s = 0, m_m = 0, m_h = 0;
    bit m_tick = 0, m_al = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic tk, input logic [5:0] s,
                                         input logic [3:0] h2, input logic [3:0] h1,
                                         input logic [3:0] m2, input logic [3:0] m1,
                                         input logic p, input logic a);
        return {7'd0, tk, s, h2, h1, m2, m1, p, a};
    endfunction

    function automatic logic [31:0] obs_pack();
        return pack(sec_tick, seconds, hours2, hours1, minutes2, minutes1, pm, alarm);
    endfunction

    function automatic logic [31:0] model_pack();
        int hd;
        bit p;
        hd = mode12 ? ((m_h + 11) % 12) + 1 : m_h;
        p  = mode12 && (m_h >= 12);
        return pack(m_tick, 6'(m_s), 4'(hd / 10), 4'(hd % 10),
                    4'(m_m / 10), 4'(m_m % 10), p, m_al);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_s = 0; m_m = 0; m_h = 0; m_tick = 0; m_al = 0;
    endtask

    task automatic model_step(input bit c, input bit im, input bit ih, input bit ack);
        bit term, carry, hcarry, set_al;
        if (c) begin
            model_reset();
            return;
        end
        term   = (m_cnt == TPS - 1);
        carry  = term && (m_s == 59);
        hcarry = carry && (m_m == 59);
        m_cnt  = term ? 0 : m_cnt + 1;
        m_tick = term;
        if (term) m_s = (m_s + 1) % 60;
        if (carry || im) m_m = (m_m + 1) % 60;
        if (hcarry || ih) m_h = (m_h + 1) % 24;
        set_al = carry && alarm_en && (m_h == int'(alarm_hr)) && (m_m == int'(alarm_min));
        if (set_al) m_al = 1;
        else if (ack || !alarm_en) m_al = 0;
    endtask

    task automatic step(input bit c, input bit im, input bit ih, input bit ack);
        clear = c; inc_min = im; inc_hr = ih; alarm_ack = ack;
        model_step(c, im, ih, ack);
        exp_q.push_back(model_pack());
        @(posedge CLK100MHZ);
        #1;
        chk("cyc", obs_pack(), exp_q.pop_front());
        clear = 1'b0; inc_min = 1'b0; inc_hr = 1'b0; alarm_ack = 1'b0;
    endtask

    // Advance until the next edge is the tick that moves seconds past 'sec'.
    task automatic run_to_tick_at(input int sec);
        int n = 0;
        while (!(m_s == sec && m_cnt == TPS - 1) && n < 2000) begin
            step(0, 0, 0, 0);
            n++;
        end
        if (n >= 2000) chk("until_timeout", 32'(m_s), 32'(sec));
    endtask

    task automatic preset(input int h, input int m);
        step(1, 0, 0, 0);
        repeat (h) step(0, 0, 1, 0);
        repeat (m) step(0, 1, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK100MHZ);
        #1;
        chk("rst24", obs_pack(), pack(1'b0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        mode12 = 1'b1;
        #1;
        chk("rst12", obs_pack(), pack(1'b0, 6'd0, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0));
        mode12 = 1'b0;
        @(posedge CLK100MHZ);
        #1;
        nReset = 1'b1;
        repeat (14) step(0, 0, 0, 0);

        // Asynchronous reset mid-count, then tick cadence after release.
        nReset = 1'b0;
        #1;
        chk("arst", obs_pack(), pack(1'b0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        model_reset();
        @(posedge CLK100MHZ);
        #1;
        nReset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 0);
            chk("tick", {31'd0, sec_tick}, {31'd0, (i % 4) == 0});
        end

        // Full-day rollover.
        preset(23, 59);
        run_to_tick_at(59);
        chk("pre", obs_pack(), pack(1'b0, 6'd59, 4'd2, 4'd3, 4'd5, 4'd9, 1'b0, 1'b0));
        step(0, 0, 0, 0);
        chk("wrap24", obs_pack(), pack(1'b1, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        mode12 = 1'b1;
        #1;
        chk("wrap12", obs_pack(), pack(1'b1, 6'd0, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0));

        // 12h formatting via inc_hr.
        repeat (11) step(0, 0, 1, 0);
        chk("h11", {23'd0, hours2, hours1, pm}, {23'd0, 4'd1, 4'd1, 1'b0});
        step(0, 0, 1, 0);
        chk("h12", {23'd0, hours2, hours1, pm}, {23'd0, 4'd1, 4'd2, 1'b1});
        step(0, 0, 1, 0);
        chk("h13", {23'd0, hours2, hours1, pm}, {23'd0, 4'd0, 4'd1, 1'b1});
        repeat (10) step(0, 0, 1, 0);
        chk("h23", {23'd0, hours2, hours1, pm}, {23'd0, 4'd1, 4'd1, 1'b1});

        // Manual minute wrap leaves the hour; simultaneous tick carry and inc_min.
        mode12 = 1'b0;
        preset(10, 59);
        step(0, 1, 0, 0);
        chk("minwrap", {16'd0, hours2, hours1, minutes2, minutes1}, {16'd0, 4'd1, 4'd0, 4'd0, 4'd0});
        repeat (5) step(0, 1, 0, 0);
        run_to_tick_at(59);
        step(0, 1, 0, 0);
        chk("simul", {10'd0, seconds, hours2, hours1, minutes2, minutes1},
            {10'd0, 6'd0, 4'd1, 4'd0, 4'd0, 4'd6});

        // Alarm at 07:30.
        alarm_en = 1'b1; alarm_hr = 5'd7; alarm_min = 6'd30;
        preset(7, 29);
        run_to_tick_at(59);
        step(0, 0, 0, 0);
        chk("alarm_set", obs_pack(), pack(1'b1, 6'd0, 4'd0, 4'd7, 4'd3, 4'd0, 1'b0, 1'b1));
        step(0, 0, 0, 1);
        chk("alarm_ack", {31'd0, alarm}, 32'd0);
        preset(7, 29);
        step(0, 1, 0, 0);
        chk("alarm_manual", {15'd0, hours2, hours1, minutes2, minutes1, alarm},
            {15'd0, 4'd0, 4'd7, 4'd3, 4'd0, 1'b0});
        repeat (2) step(0, 0, 0, 0);
        preset(7, 29);
        run_to_tick_at(59);
        step(0, 0, 0, 1);
        chk("set_over_ack", {31'd0, alarm}, 32'd1);

        // clear beats inc_hr and a tick, prescaler restarts.
        for (int n = 0; n < 8 && m_cnt != TPS - 1; n++) step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        chk("clear", obs_pack(), pack(1'b0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0);
            chk("clr_tick", {31'd0, sec_tick}, {31'd0, i == 4});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
